square_compose: RTL and testbench

- Inverse companion to the sequential square-root unit: takes a (root, remainder) pair and rebuilds the radicand as root*root + remainder.
- Sequential shift-add squarer with a start/finish handshake matching the root unit's handshake.
- Optional check mode compares the rebuilt value against an expected radicand and validates the remainder range.
- Placed downstream of the root unit for self-check, or used standalone as a squarer.

---
 rtl/square_pkg.sv | 16 +
 rtl/square_compose_if.sv | 29 ++
 rtl/square_shift_mul.sv | 34 +++
 rtl/square_compose.sv | 93 +++++++++
 tb/tb_square_compose.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/square_pkg.sv
// Shared types and constants for the square composer and its companion root unit.
package square_pkg;

    localparam int ROOT_W_DEF = 8;

    localparam logic MODE_COMPUTE = 1'b0;
    localparam logic MODE_CHECK   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/square_compose_if.sv
// Request/result bundle between a client and the square composer.
interface square_compose_if
    import square_pkg::*;
#(
    parameter int ROOT_W = ROOT_W_DEF,
    parameter int REM_W  = ROOT_W + 1,
    parameter int OUT_W  = 2 * ROOT_W + 1
);
    logic [2:0]          mode;
    logic [ROOT_W-1:0]   sqr_root;
    logic [REM_W-1:0]    remainder;
    logic [2*ROOT_W-1:0] data_in;
    logic                start;
    logic [OUT_W-1:0]    data_out;
    logic                rem_ok;
    logic                match;
    logic                busy;
    logic                finish;

    modport master (
        output mode, sqr_root, remainder, data_in, start,
        input  data_out, rem_ok, match, busy, finish
    );

    modport slave (
        input  mode, sqr_root, remainder, data_in, start,
        output data_out, rem_ok, match, busy, finish
    );
endinterface

// File: rtl/square_shift_mul.sv
// LSB-first shift-add squarer core: one root bit per step, ROOT_W steps per product.
module square_shift_mul #(
    parameter int ROOT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
    input  logic [ROOT_W-1:0]   root,
    output logic                done,
    output logic [2*ROOT_W-1:0] prod
);
    localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

    logic [CNT_W-1:0]    cnt;
    logic [2*ROOT_W-1:0] addend;

    assign addend = {{ROOT_W{1'b0}}, root} << cnt;
    assign done   = (cnt == CNT_W'(ROOT_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            prod <= '0;
        end else if (load) begin
            cnt  <= '0;
            prod <= '0;
        end else if (step) begin
            if (root[cnt])
                prod <= prod + addend;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/square_compose.sv
// Rebuilds a radicand as root*root + remainder; optional check against an expected value.
module square_compose
    import square_pkg::*;
#(
    parameter int ROOT_W = ROOT_W_DEF,
    parameter int REM_W  = ROOT_W + 1,
    parameter int OUT_W  = 2 * ROOT_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    square_compose_if.slave  bus
);
    state_t state, state_nx;

    logic [ROOT_W-1:0]   root_q;
    logic [REM_W-1:0]    rem_q;
    logic [2*ROOT_W-1:0] data_q;
    logic                mode_q;

    logic                load, step, mul_done;
    logic [2*ROOT_W-1:0] prod;
    logic [OUT_W-1:0]    sum;

    square_shift_mul #(.ROOT_W(ROOT_W)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .root  (root_q),
        .done  (mul_done),
        .prod  (prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                load     = 1'b1;
                state_nx = MUL;
            end
            MUL: begin
                step = 1'b1;
                if (mul_done) state_nx = ADD;
            end
            ADD:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands are captured at acceptance so the client may move on immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_q <= '0;
            rem_q  <= '0;
            data_q <= '0;
            mode_q <= MODE_COMPUTE;
        end else if (load) begin
            root_q <= bus.sqr_root;
            rem_q  <= bus.remainder;
            data_q <= bus.data_in;
            mode_q <= bus.mode[0];
        end
    end

    // Full-width sum: an out-of-range remainder carries into the top bit.
    assign sum = {1'b0, prod} + {{(OUT_W-REM_W){1'b0}}, rem_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_out <= '0;
            bus.rem_ok   <= 1'b0;
            bus.match    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.finish   <= 1'b0;
        end else begin
            bus.busy   <= (state_nx != IDLE);
            bus.finish <= (state_nx == DONE);
            if (state == ADD) begin
                bus.data_out <= sum;
                bus.rem_ok   <= (rem_q <= {root_q, 1'b0});
                bus.match    <= (mode_q == MODE_CHECK) && (sum == {1'b0, data_q});
            end
        end
    end
endmodule

// File: tb/tb_square_compose.sv
// Directed bench for square_compose: arithmetic, check mode, handshake and reset.
module tb_square_compose;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    square_compose_if #(.ROOT_W(8)) bif ();

    square_compose #(.ROOT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issues one request, scrambles the inputs after acceptance, returns finish latency.
    task automatic run_op(input logic [7:0] r, input logic [8:0] m, input logic [15:0] d,
                          input logic cm, output int lat);
        @(negedge clk);
        bif.sqr_root  = r;
        bif.remainder = m;
        bif.data_in   = d;
        bif.mode      = {2'b00, cm};
        bif.start     = 1'b1;
        @(posedge clk);
        #1;
        bif.start     = 1'b0;
        bif.sqr_root  = ~r;
        bif.remainder = ~m;
        bif.data_in   = ~d;
        bif.mode      = {2'b11, ~cm};
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bif.finish) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int nfin, first_fin, second_fin;

        rst_n         = 1'b0;
        bif.start     = 1'b0;
        bif.mode      = 3'b000;
        bif.sqr_root  = 8'd0;
        bif.remainder = 9'd0;
        bif.data_in   = 16'd0;
        #12;
        chk("rst_data_out", 32'(bif.data_out), 32'd0);
        chk("rst_flags", {27'd0, bif.rem_ok, bif.match, bif.busy, bif.finish, 1'b0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'd255, 9'd0, 16'd0, 1'b0, lat);
        chk("lat_255", 32'(lat), 32'd10);
        chk("sq_255", 32'(bif.data_out), 32'd65025);
        chk("remok_255", 32'(bif.rem_ok), 32'd1);
        chk("match_compute", 32'(bif.match), 32'd0);
        chk("busy_in_done", 32'(bif.busy), 32'd1);
        @(negedge clk);
        chk("finish_pulse_end", {30'd0, bif.finish, bif.busy}, 32'd0);

        run_op(8'd16, 9'd32, 16'd0, 1'b0, lat);
        chk("sq_16_32", 32'(bif.data_out), 32'd288);
        chk("remok_16_32", 32'(bif.rem_ok), 32'd1);
        run_op(8'd16, 9'd33, 16'd0, 1'b0, lat);
        chk("sq_16_33", 32'(bif.data_out), 32'd289);
        chk("remok_16_33", 32'(bif.rem_ok), 32'd0);

        run_op(8'd255, 9'd511, 16'd0, 1'b1, lat);
        chk("ovf_data", 32'(bif.data_out), 32'd65536);
        chk("ovf_remok", 32'(bif.rem_ok), 32'd0);
        chk("ovf_match", 32'(bif.match), 32'd0);

        run_op(8'd200, 9'd100, 16'd40100, 1'b1, lat);
        chk("chk_data", 32'(bif.data_out), 32'd40100);
        chk("chk_match", 32'(bif.match), 32'd1);
        repeat (4) @(negedge clk);
        chk("hold_data", 32'(bif.data_out), 32'd40100);
        chk("hold_match", 32'(bif.match), 32'd1);
        run_op(8'd200, 9'd100, 16'd40101, 1'b1, lat);
        chk("chk_nomatch", 32'(bif.match), 32'd0);

        // Start re-pulsed while busy must not queue a second operation.
        @(negedge clk);
        bif.sqr_root  = 8'd5;
        bif.remainder = 9'd1;
        bif.mode      = 3'b000;
        bif.start     = 1'b1;
        nfin = 0;
        first_fin = 0;
        @(posedge clk);
        #1;
        bif.start    = 1'b0;
        bif.sqr_root = 8'd7;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (bif.finish) begin
                nfin++;
                if (first_fin == 0) first_fin = k;
            end
            bif.start = (k == 3) || (k == 9);
        end
        bif.start = 1'b0;
        chk("repulse_count", 32'(nfin), 32'd1);
        chk("repulse_lat", 32'(first_fin), 32'd10);
        chk("repulse_data", 32'(bif.data_out), 32'd26);

        // Start held high: one operation every 11 cycles.
        @(negedge clk);
        bif.sqr_root  = 8'd3;
        bif.remainder = 9'd0;
        bif.start     = 1'b1;
        nfin = 0;
        first_fin = 0;
        second_fin = 0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (bif.finish) begin
                nfin++;
                if (nfin == 1) first_fin = k;
                if (nfin == 2) second_fin = k;
            end
        end
        bif.start = 1'b0;
        chk("held_count", 32'(nfin), 32'd3);
        chk("held_first", 32'(first_fin), 32'd10);
        chk("held_period", 32'(second_fin - first_fin), 32'd11);
        repeat (15) @(negedge clk);
        chk("held_data", 32'(bif.data_out), 32'd9);

        // Asynchronous reset in the middle of MUL aborts with no finish.
        @(negedge clk);
        bif.sqr_root  = 8'd9;
        bif.remainder = 9'd0;
        bif.start     = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_data", 32'(bif.data_out), 32'd0);
        chk("midrst_busy", 32'(bif.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nfin = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bif.finish) nfin++;
        end
        chk("midrst_nofinish", 32'(nfin), 32'd0);
        run_op(8'd3, 9'd2, 16'd0, 1'b0, lat);
        chk("post_rst_lat", 32'(lat), 32'd10);
        chk("post_rst_data", 32'(bif.data_out), 32'd11);

        for (int r = 0; r < 256; r++) begin
            run_op(8'(r), 9'(2 * r), 16'd0, 1'b0, lat);
            chk("sweep_data", 32'(bif.data_out), 32'((r + 1) * (r + 1) - 1));
            chk("sweep_remok", 32'(bif.rem_ok), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
